// File: rtl/gpio_step_gen.sv
// Two-axis step/direction pulse generator driven by GPIO command words.
// Returns packed axis status plus a completion latch strobe for the GPIO emulator.
module gpio_step_gen #(
  parameter int unsigned MIN_HALF = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cmd_in,
  input  logic        cmd_load,
  output logic [1:0]  step_out,
  output logic [1:0]  dir_out,
  output logic [1:0]  busy,
  output logic [31:0] status_out,
  output logic        status_latch
);

  localparam int unsigned NAX = 2;
  localparam int unsigned CW  = 14;
  localparam int unsigned HW  = 16;

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  // Command word fields
  logic          cmd_axis;
  logic          cmd_dir;
  logic [CW-1:0] cmd_n;
  logic [HW-1:0] cmd_p;
  logic [HW-1:0] cmd_pe;

  assign cmd_axis = cmd_in[31];
  assign cmd_dir  = cmd_in[30];
  assign cmd_n    = cmd_in[29:16];
  assign cmd_p    = cmd_in[15:0];
  assign cmd_pe   = (cmd_p < HW'(MIN_HALF)) ? HW'(MIN_HALF) : cmd_p;

  // Next-cycle values gathered from both axes feed the registered outputs
  logic [NAX-1:0]         step_nx;
  logic [NAX-1:0]         dir_nx;
  logic [NAX-1:0]         busy_nx;
  logic [NAX-1:0]         ovr_nx;
  logic [NAX-1:0]         done_nx;
  logic [NAX-1:0][CW-1:0] pos_nx;

  for (genvar a = 0; a < NAX; a++) begin : g_axis
    state_t        state_q, state_d;
    logic [HW-1:0] half_q, half_d;
    logic [HW-1:0] pe_q, pe_d;
    logic [CW-1:0] rem_q, rem_d;
    logic [CW-1:0] pos_q, pos_d;
    logic          ovr_q, ovr_d;
    logic          dir_q, dir_d;
    logic          step_d;
    logic          done_d;
    logic          hit;

    assign hit = cmd_load && (cmd_axis == 1'(a));

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= IDLE;
        half_q  <= '0;
        pe_q    <= '0;
        rem_q   <= '0;
        pos_q   <= '0;
        ovr_q   <= 1'b0;
        dir_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        half_q  <= half_d;
        pe_q    <= pe_d;
        rem_q   <= rem_d;
        pos_q   <= pos_d;
        ovr_q   <= ovr_d;
        dir_q   <= dir_d;
      end
    end

    // half_q counts cycles left in the current phase, minus one
    always_comb begin
      state_d = state_q;
      half_d  = half_q;
      pe_d    = pe_q;
      rem_d   = rem_q;
      pos_d   = pos_q;
      ovr_d   = ovr_q;
      dir_d   = dir_q;
      step_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
        IDLE: begin
          if (hit && (cmd_n != '0)) begin
            state_d = LOW;
            half_d  = cmd_pe - HW'(1);
            pe_d    = cmd_pe;
            rem_d   = cmd_n;
            dir_d   = cmd_dir;
          end
        end
        LOW: begin
          if (half_q == '0) begin
            state_d = HIGH;
            half_d  = pe_q - HW'(1);
            step_d  = 1'b1;
            pos_d   = dir_q ? (pos_q + CW'(1)) : (pos_q - CW'(1));
          end else begin
            half_d = half_q - HW'(1);
          end
        end
        HIGH: begin
          if (half_q == '0) begin
            if (rem_q == CW'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = LOW;
              half_d  = pe_q - HW'(1);
            end
            rem_d = rem_q - CW'(1);
          end else begin
            half_d = half_q - HW'(1);
            step_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
      // A zero-length command only clears overrun; a real one while moving is dropped
      if (hit) begin
        if (cmd_n == '0) begin
          ovr_d = 1'b0;
        end else if (state_q != IDLE) begin
          ovr_d = 1'b1;
        end
      end
    end

    assign step_nx[a] = step_d;
    assign dir_nx[a]  = dir_d;
    assign busy_nx[a] = (state_d != IDLE);
    assign ovr_nx[a]  = ovr_d;
    assign done_nx[a] = done_d;
    assign pos_nx[a]  = pos_d;
  end

  // Outputs and status register together so status matches the pins every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      step_out     <= '0;
      dir_out      <= '0;
      busy         <= '0;
      status_out   <= '0;
      status_latch <= 1'b0;
    end else begin
      step_out     <= step_nx;
      dir_out      <= dir_nx;
      busy         <= busy_nx;
      status_out   <= {busy_nx[1], busy_nx[0], ovr_nx[1], ovr_nx[0], pos_nx[1], pos_nx[0]};
      status_latch <= |done_nx;
    end
  end

endmodule

// File: tb/tb_gpio_step_gen.sv
// Bench for gpio_step_gen: directed scenarios plus random traffic, all checked
// against a timeline model that derives each axis state from elapsed cycles.
module tb_gpio_step_gen;

  localparam int unsigned MIN_HALF = 2;

  logic        clk;
  logic        reset;
  logic [31:0] cmd_in;
  logic        cmd_load;
  logic [1:0]  step_out;
  logic [1:0]  dir_out;
  logic [1:0]  busy;
  logic [31:0] status_out;
  logic        status_latch;

  gpio_step_gen #(.MIN_HALF(MIN_HALF)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_in       (cmd_in),
    .cmd_load     (cmd_load),
    .step_out     (step_out),
    .dir_out      (dir_out),
    .busy         (busy),
    .status_out   (status_out),
    .status_latch (status_latch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int latch_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  // Model: a move is its start edge, length and half period; everything else is arithmetic
  longint      t;
  bit          act  [2];
  longint      s    [2];
  longint      n    [2];
  longint      pe   [2];
  bit          mdir [2];
  bit          movr [2];
  logic [13:0] base [2];

  function automatic longint dur(int a);
    return 2 * n[a] * pe[a];
  endfunction

  function automatic bit mbusy(int a, longint tt);
    return act[a] && ((tt - s[a]) < dur(a));
  endfunction

  function automatic bit mstep(int a, longint tt);
    return mbusy(a, tt) && ((((tt - s[a]) / pe[a]) % 2) == 1);
  endfunction

  function automatic logic [13:0] mpos(int a, longint tt);
    longint k;
    if (!act[a]) return base[a];
    k = mbusy(a, tt) ? ((((tt - s[a]) / pe[a]) + 1) / 2) : n[a];
    return mdir[a] ? (base[a] + 14'(k)) : (base[a] - 14'(k));
  endfunction

  task automatic model_edge(input logic rst, input logic ld, input logic [31:0] cmd);
    int     a;
    longint nn, p;
    t++;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        act[i] = 0; base[i] = '0; movr[i] = 0; mdir[i] = 0;
      end
    end else if (ld) begin
      a  = int'(cmd[31]);
      nn = longint'(cmd[29:16]);
      p  = longint'(cmd[15:0]);
      if (p < MIN_HALF) p = MIN_HALF;
      if (nn == 0) movr[a] = 0;
      else if (mbusy(a, t - 1)) movr[a] = 1;
      else begin
        base[a] = mpos(a, t - 1);
        act[a] = 1; s[a] = t; n[a] = nn; pe[a] = p; mdir[a] = cmd[30];
      end
    end
  endtask

  task automatic compare_all();
    logic [1:0]  eb, es, ed;
    logic        el;
    logic [31:0] est;
    el = 1'b0;
    for (int a = 0; a < 2; a++) begin
      eb[a] = mbusy(a, t);
      es[a] = mstep(a, t);
      ed[a] = mdir[a];
      if (act[a] && ((t - s[a]) == dur(a))) el = 1'b1;
    end
    est = {eb[1], eb[0], movr[1], movr[0], mpos(1, t), mpos(0, t)};
    chk("step", 32'(step_out), 32'(es));
    chk("dir", 32'(dir_out), 32'(ed));
    chk("busy", 32'(busy), 32'(eb));
    chk("status", status_out, est);
    chk("latch", 32'(status_latch), 32'(el));
    if (status_latch) latch_cnt++;
  endtask

  task automatic cycle(input logic rst, input logic ld, input logic [31:0] cmd);
    reset = rst; cmd_load = ld; cmd_in = cmd;
    @(posedge clk);
    model_edge(rst, ld, cmd);
    @(negedge clk);
    reset = 1'b0; cmd_load = 1'b0;
    compare_all();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    t = 0;
    for (int i = 0; i < 2; i++) begin
      act[i] = 0; s[i] = 0; n[i] = 0; pe[i] = 1; mdir[i] = 0; movr[i] = 0; base[i] = '0;
    end
    reset = 1'b0; cmd_load = 1'b0; cmd_in = '0;

    // Reset state
    cycle(1'b1, 1'b0, 32'h0);
    chk("rst_status", status_out, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // Single move then clamp with negative wrap
    latch_cnt = 0;
    cycle(1'b0, 1'b1, 32'h4003_0002);
    idle(13);
    chk("single_status", status_out, 32'h0000_0003);
    chk("single_latches", 32'(latch_cnt), 32'd1);
    cycle(1'b0, 1'b1, 32'h8002_0001);
    idle(9);
    chk("clamp_status", status_out, 32'h0FFF_8003);

    // Overrun then clear
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h400A_0004);
    idle(4);
    cycle(1'b0, 1'b1, 32'h4001_0001);
    idle(80);
    chk("ovr_pos0", 32'(status_out[13:0]), 32'd10);
    chk("ovr_bit28", 32'(status_out[28]), 32'd1);
    latch_cnt = 0;
    cycle(1'b0, 1'b1, 32'h0000_0000);
    idle(3);
    chk("ovr_clear", 32'(status_out[28]), 32'd0);
    chk("ovr_clear_latch", 32'(latch_cnt), 32'd0);

    // Reset during a HIGH phase, then a fresh move
    cycle(1'b0, 1'b1, 32'h4010_0003);
    idle(4);
    cycle(1'b1, 1'b0, 32'h0);
    chk("midrst_status", status_out, 32'h0);
    cycle(1'b0, 1'b1, 32'h4003_0002);
    idle(13);
    chk("after_rst_status", status_out, 32'h0000_0003);

    // Back-to-back axes
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h4002_0002);
    cycle(1'b0, 1'b1, 32'hC002_0002);
    idle(10);
    chk("b2b_status", status_out, 32'h0000_8002);

    // Both axes finishing on the same edge
    latch_cnt = 0;
    cycle(1'b0, 1'b1, 32'h4002_0002);
    idle(3);
    cycle(1'b0, 1'b1, 32'hC001_0002);
    idle(8);
    chk("same_latches", 32'(latch_cnt), 32'd1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic        r, l;
      logic [31:0] c;
      r = ($urandom_range(0, 249) == 0);
      l = ($urandom_range(0, 5) == 0);
      c[31]    = 1'($urandom_range(0, 1));
      c[30]    = 1'($urandom_range(0, 1));
      c[29:16] = ($urandom_range(0, 4) == 0) ? 14'd0 : 14'($urandom_range(1, 5));
      c[15:0]  = 16'($urandom_range(0, 4));
      cycle(r, l, c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpio_step_gen.md
Name: gpio_step_gen

Overview:
- Two-axis step/direction pulse generator that sits downstream of the GPIO emulator.
- Consumes the emulator's gpio_out command word on a load strobe and drives step/dir outputs for axis 0 and axis 1.
- Returns a packed status word plus a one-cycle latch strobe, which wire directly to the emulator's gpio_in and gpio_latch so the host can read axis state back over the bus.

Parameters:
- MIN_HALF, default 2: minimum half-period in clk cycles; smaller commanded values are clamped up to it (legal range 1..65535).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- cmd_in  input  32  command word (from emulator gpio_out).
- cmd_load  input  1  one-cycle strobe; cmd_in sampled when high.
- step_out  output  2  step pulse per axis (bit0 = axis 0).
- dir_out  output  2  direction per axis; 1 = positive.
- busy  output  2  axis executing a move.
- status_out  output  32  packed status (to emulator gpio_in).
- status_latch  output  1  one-cycle strobe (to emulator gpio_latch).

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Port names are clk and reset.
- Command format:
  - [31] axis select.
  - [30] dir.
  - [29:16] step count N (unsigned 14 bit).
  - [15:0] half-period P.
  - Effective half-period Pe = max(P, MIN_HALF).
- Status format: status_out = {busy[1], busy[0], ovr1, ovr0, pos1[13:0], pos0[13:0]}.
  - pos0 and pos1 are 14-bit two's complement.
  - status_out is registered and reflects state in the same cycle as the outputs.
- Reset: when reset is high at an edge, every output, position, overrun flag and FSM is forced to 0/IDLE. This holds mid-move (the move is abandoned, step_out drops next edge) and takes priority over cmd_load.
- Per-axis FSM states: IDLE, LOW, HIGH, with a half-period counter and a remaining-step counter.
- IDLE, cmd_load at edge T for this axis with N>0:
  - At T+1: busy=1, dir_out=cmd[30], step_out=0, state LOW.
  - LOW lasts Pe cycles, then HIGH.
  - On entry to HIGH: step_out=1 and pos += 1 (dir=1) or pos -= 1 (dir=0), wrapping modulo 2^14 (14'h1FFF+1 -> 14'h2000; 14'h0000-1 -> 14'h3FFF).
  - HIGH lasts Pe cycles, then the remaining count decrements. If nonzero, go to LOW; else go to IDLE.
  - Total busy duration is exactly 2*N*Pe cycles: busy is high from T+1 through T+2*N*Pe.
- Completion: in the first IDLE cycle (T+2*N*Pe+1):
  - busy=0 and step_out=0.
  - status_latch=1 for exactly one cycle, with status_out already showing the final pos and busy=0.
  - If both axes complete in the same cycle, a single status_latch pulse is produced.
- Command with N=0:
  - No motion, no busy, no status_latch.
  - Clears that axis's sticky ovr flag, whether the axis is idle or busy.
  - Does not change dir_out.
- Overrun: cmd_load with N>0 addressed to an axis with busy=1 is dropped and sets that axis's ovr flag at the next edge. This includes the axis's final HIGH cycle; busy is still 1 then.
- Axes are fully independent; a command to one axis never disturbs the other.
- dir_out holds its last value while idle.

Test Plan:
- Single move: reset, then cmd_in=32'h4003_0002 with cmd_load pulsed.
  - Required: dir_out[0]=1 and busy[0]=1 for exactly 12 cycles.
  - step_out[0] shows 3 pulses, each 2 high / 2 low.
  - At completion: status_latch single pulse and status_out=32'h0000_0003.
- Clamp plus negative wrap: after the single-move scenario, cmd_in=32'h8002_0001.
  - Required: Pe=2, busy[1]=1 for 8 cycles, two step_out[1] pulses, dir_out[1]=0.
  - Final status_out=32'h0FFF_8003 (pos1=14'h3FFE).
- Overrun then clear:
  - Start 32'h400A_0004; 5 cycles later load 32'h4001_0001.
    - Required: command ignored, total pos0 change = +10, status bit28 (ovr0)=1.
  - Then load 32'h0000_0000.
    - Required: bit28 clears, no busy, no status_latch.
- Reset mid-move: start 32'h4010_0003; assert reset for 1 cycle during a HIGH phase.
  - Required: next cycle step_out=0, busy=0, status_out=0, no status_latch.
  - A fresh command then runs normally.
- Back-to-back axes: load 32'h4002_0002, then 32'hC002_0002 one cycle later.
  - Required: two status_latch pulses exactly one cycle apart.
  - Final status_out=32'h0000_8002.
- Same-cycle completion: two axis moves timed so both finish on the same edge.
  - Required: exactly one status_latch pulse, with both busy bits 0 in that cycle.
